// File: rtl/wsg_pkg.sv
// Shared types and register-map constants for the WSG voice scheduler.
package wsg_pkg;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_ACC, S_OUT} wsg_state_t;

   localparam logic [4:0] WAVE_BASE    = 5'h05;
   localparam logic [4:0] FREQ_BASE    = 5'h10;
   localparam logic [4:0] VOL_BASE     = 5'h15;
   localparam int         VOICE_STRIDE = 5;
   localparam int         PHASE_W      = 20;
   localparam int         SAMPLE_W     = 10;

   function automatic logic [4:0] reg_idx(input logic [4:0] base, input logic [1:0] v,
                                          input logic [2:0] off);
      return base + 5'(VOICE_STRIDE) * {3'b000, v} + {2'b00, off};
   endfunction

endpackage

// File: rtl/wsg_regfile.sv
// 32 x 4-bit sound register file with a voice-indexed field read mux.
module wsg_regfile import wsg_pkg::*; (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_we,
   input  logic [4:0]         i_addr,
   input  logic [3:0]         i_din,
   input  logic [1:0]         i_voice,
   output logic [3:0]         o_wave,
   output logic [3:0]         o_vol,
   output logic [PHASE_W-1:0] o_freq
);

   logic [3:0] r_regs [32];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (i_we) begin
         r_regs[i_addr] <= i_din;
      end
   end

   // Only voice 0 owns the low frequency nibble; the others read it as zero.
   assign o_wave = r_regs[reg_idx(WAVE_BASE, i_voice, 3'd0)];
   assign o_vol  = r_regs[reg_idx(VOL_BASE, i_voice, 3'd0)];
   assign o_freq = {r_regs[reg_idx(FREQ_BASE, i_voice, 3'd4)],
                    r_regs[reg_idx(FREQ_BASE, i_voice, 3'd3)],
                    r_regs[reg_idx(FREQ_BASE, i_voice, 3'd2)],
                    r_regs[reg_idx(FREQ_BASE, i_voice, 3'd1)],
                    (i_voice == 2'd0) ? r_regs[FREQ_BASE] : 4'h0};

endmodule

// File: rtl/wsg_scheduler.sv
// Three-voice wavetable sequencer: per sample tick, fetch/scale/mix each voice and emit one sample.
// Optional WSG_SOUND_ENABLE_EN adds a sound_en input that mutes output and freezes phases.
module wsg_scheduler import wsg_pkg::*; #(
   parameter int CLK_HZ    = 47828000,
   parameter int SAMPLE_HZ = 96000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                reg_we,
   input  logic [4:0]          reg_addr,
   input  logic [3:0]          reg_din,
`ifdef WSG_SOUND_ENABLE_EN
   input  logic                sound_en,
`endif
   output logic                prom_rd,
   output logic [7:0]          prom_addr,
   output logic                prom_bank,
   input  logic [3:0]          prom_dout,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid
);

   localparam int DIV   = CLK_HZ / SAMPLE_HZ;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   generate
      if (DIV < 16) begin : g_div_chk
         $error("wsg_scheduler: CLK_HZ/SAMPLE_HZ must be at least 16");
      end
   endgenerate

   wsg_state_t          r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_tick;
   logic [1:0]          r_voice;
   logic [PHASE_W-1:0]  r_phase [3];
   logic [PHASE_W-1:0]  r_freq;
   logic [3:0]          r_vol;
   logic [7:0]          r_prom_addr;
   logic                r_prom_bank;
   logic [SAMPLE_W-1:0] r_acc, r_sample;
   logic                r_valid;
   logic                w_snd_en;
   logic [3:0]          w_wave, w_vol;
   logic [PHASE_W-1:0]  w_freq;
   logic [7:0]          w_addr;
   logic signed [7:0]   w_vol8, w_dif8, w_term;
   logic [SAMPLE_W-1:0] w_term_x;

`ifdef WSG_SOUND_ENABLE_EN
   assign w_snd_en = sound_en;
`else
   assign w_snd_en = 1'b1;
`endif

   wsg_regfile u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .i_we    (reg_we),
      .i_addr  (reg_addr),
      .i_din   (reg_din),
      .i_voice (r_voice),
      .o_wave  (w_wave),
      .o_vol   (w_vol),
      .o_freq  (w_freq)
   );

   assign w_addr   = {w_wave[2:0], r_phase[r_voice][PHASE_W-1 -: 5]};
   assign w_vol8   = {4'b0000, r_vol};
   assign w_dif8   = {4'b0000, prom_dout} - 8'd7;
   assign w_term   = w_vol8 * w_dif8;
   assign w_term_x = {{(SAMPLE_W-8){w_term[7]}}, w_term};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (r_tick) w_next = S_ADDR;
         S_ADDR:  w_next = S_WAIT;
         S_WAIT:  w_next = S_ACC;
         S_ACC:   w_next = (r_voice == 2'd2) ? S_OUT : S_ADDR;
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address is live during ADDR and held from the latch afterwards.
   always_comb begin
      prom_rd   = 1'b0;
      prom_addr = r_prom_addr;
      prom_bank = r_prom_bank;
      if (r_state == S_ADDR) begin
         prom_rd   = 1'b1;
         prom_addr = w_addr;
         prom_bank = w_wave[3];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_tick      <= 1'b0;
         r_voice     <= '0;
         for (int i = 0; i < 3; i++) r_phase[i] <= '0;
         r_freq      <= '0;
         r_vol       <= '0;
         r_prom_addr <= '0;
         r_prom_bank <= 1'b0;
         r_acc       <= '0;
         r_sample    <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_tick  <= (r_cnt == CNT_MAX);
         r_cnt   <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: r_voice <= '0;
            // Volume and frequency are frozen here so later writes miss this voice.
            S_ADDR: begin
               r_prom_addr <= w_addr;
               r_prom_bank <= w_wave[3];
               r_vol       <= w_vol;
               r_freq      <= w_freq;
            end
            S_ACC: begin
               r_acc   <= (r_voice == 2'd0) ? w_term_x : r_acc + w_term_x;
               if (w_snd_en) r_phase[r_voice] <= r_phase[r_voice] + r_freq;
               r_voice <= r_voice + 2'd1;
            end
            S_OUT: begin
               r_sample <= r_acc;
               r_valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sample_out   = w_snd_en ? r_sample : '0;
   assign sample_valid = r_valid;

endmodule

// File: tb/tb_wsg_scheduler.sv
// Directed bench for wsg_scheduler with a registered constant-data PROM model.
module tb_wsg_scheduler;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              reg_we = 1'b0;
   logic [4:0]        reg_addr = '0;
   logic [3:0]        reg_din = '0;
   logic              sound_en = 1'b1;
   logic              prom_rd;
   logic [7:0]        prom_addr;
   logic              prom_bank;
   logic [3:0]        prom_dout;
   logic signed [9:0] sample_out;
   logic              sample_valid;

   logic [3:0] prom_val = 4'h0;
   logic [3:0] prom_q = 4'h0;
   logic [7:0] cap_addr [3];
   logic       cap_bank [3];
   int         rd_k = 0;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   wsg_scheduler #(.CLK_HZ(20), .SAMPLE_HZ(1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .reg_we       (reg_we),
      .reg_addr     (reg_addr),
      .reg_din      (reg_din),
`ifdef WSG_SOUND_ENABLE_EN
      .sound_en     (sound_en),
`endif
      .prom_rd      (prom_rd),
      .prom_addr    (prom_addr),
      .prom_bank    (prom_bank),
      .prom_dout    (prom_dout),
      .sample_out   (sample_out),
      .sample_valid (sample_valid)
   );

   always @(posedge clk) if (prom_rd) prom_q <= prom_val;
   assign prom_dout = prom_q;

   // Record each voice's fetch address in sequence order.
   always @(negedge clk) begin
      if (!reset_n) rd_k <= 0;
      else if (prom_rd) begin
         cap_addr[rd_k] <= prom_addr;
         cap_bank[rd_k] <= prom_bank;
         rd_k <= (rd_k == 2) ? 0 : rd_k + 1;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [3:0] d);
      @(negedge clk);
      reg_we = 1'b1; reg_addr = a; reg_din = d;
      @(negedge clk);
      reg_we = 1'b0;
   endtask

   task automatic get_sample(output int s);
      int n = 0;
      s = 0;
      @(negedge clk);
      while (!sample_valid && n < 100) begin @(negedge clk); n++; end
      if (!sample_valid) chk("sample_timeout", 0, 1);
      else s = int'(sample_out);
   endtask

   task automatic wait_rd();
      int n = 0;
      while (!prom_rd && n < 100) begin @(negedge clk); n++; end
      if (!prom_rd) chk("rd_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      reg_we  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sample", int'(sample_out), 0);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_rd", int'(prom_rd), 0);
      chk("rst_addr", int'(prom_addr), 0);
      chk("rst_bank", int'(prom_bank), 0);
      reset_n = 1'b1;
   endtask

   initial begin
      int s, n, m, early, errs, nv;

      // Reset state and first-tick / latency timing
      do_reset();
      n = 0; early = 0;
      while (!prom_rd && n < 100) begin
         @(negedge clk); n++;
         if (sample_valid) early++;
      end
      chk("early_valid", early, 0);
      chk("first_rd", n, 21);
      m = 0;
      while (!sample_valid && m < 100) begin @(negedge clk); m++; end
      chk("latency", m, 10);
      chk("zero_vol_sample", int'(sample_out), 0);

      // Voice 0 only at full volume
      write_reg(5'h15, 4'hF);
      prom_val = 4'hF;
      get_sample(s); get_sample(s);
      chk("v0_max", s, 120);
      prom_val = 4'h0;
      get_sample(s); get_sample(s);
      chk("v0_min", s, -105);

      // All three voices at full volume
      write_reg(5'h1A, 4'hF);
      write_reg(5'h1F, 4'hF);
      prom_val = 4'hF;
      get_sample(s); get_sample(s);
      chk("all_max", s, 360);
      prom_val = 4'h0;
      get_sample(s); get_sample(s);
      chk("all_min", s, -315);

      // Mixed volumes: 3*3 + 5*3 + 0*3
      write_reg(5'h15, 4'h3);
      write_reg(5'h1A, 4'h5);
      write_reg(5'h1F, 4'h0);
      prom_val = 4'hA;
      get_sample(s); get_sample(s);
      chk("mixed", s, 24);

      // Wave select: voice 1 uses PROM B, wave bits 3
      write_reg(5'h0A, 4'hB);
      get_sample(s); get_sample(s);
      chk("v1_bank", int'(cap_bank[1]), 1);
      chk("v1_wave", int'(cap_addr[1][7:5]), 3);
      chk("v0_bank", int'(cap_bank[0]), 0);

      // Write during voice-0 WAIT applies to the next sample only
      write_reg(5'h15, 4'hF);
      write_reg(5'h1A, 4'h0);
      prom_val = 4'hF;
      get_sample(s); get_sample(s);
      chk("pre_write", s, 120);
      wait_rd();
      write_reg(5'h15, 4'h5);
      get_sample(s);
      chk("write_late", s, 120);
      get_sample(s);
      chk("write_next", s, 40);

      // Phase stepping of voice 1 at freq 0x01000 across a full wrap
      do_reset();
      write_reg(5'h18, 4'h1);
      errs = 0;
      for (int k = 0; k < 257; k++) begin
         get_sample(s);
         if (int'(cap_addr[1][4:0]) != ((k >> 3) % 32)) errs++;
         if (k == 7)   chk("idx_7", int'(cap_addr[1][4:0]), 0);
         if (k == 8)   chk("idx_8", int'(cap_addr[1][4:0]), 1);
         if (k == 255) chk("idx_255", int'(cap_addr[1][4:0]), 31);
         if (k == 256) chk("idx_wrap", int'(cap_addr[1][4:0]), 0);
      end
      chk("idx_seq_errs", errs, 0);
      chk("v0_frozen", int'(cap_addr[0]), 0);

      // Reset in the middle of voice-0 ACC
      do_reset();
      write_reg(5'h18, 4'h8);
      write_reg(5'h15, 4'hF);
      prom_val = 4'hF;
      get_sample(s); get_sample(s); get_sample(s);
      chk("pre_idx", int'(cap_addr[1][4:0]), 2);
      chk("pre_sample", s, 120);
      wait_rd();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_rd", int'(prom_rd), 0);
      chk("mid_rst_addr", int'(prom_addr), 0);
      chk("mid_rst_sample", int'(sample_out), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      nv = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (sample_valid) nv++;
      end
      chk("mid_rst_no_valid", nv, 0);
      chk("mid_rst_phase", int'(cap_addr[1][4:0]), 0);

`ifdef WSG_SOUND_ENABLE_EN
      write_reg(5'h18, 4'h8);
      write_reg(5'h15, 4'hF);
      get_sample(s); get_sample(s);
      sound_en = 1'b0;
      get_sample(s);
      m = int'(cap_addr[1][4:0]);
      get_sample(s); get_sample(s);
      chk("mute_sample", s, 0);
      chk("mute_frozen", int'(cap_addr[1][4:0]), m);
      sound_en = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
